fifo_sync_param: RTL and testbench
==================================

# fifo_sync_param

Parametrised synchronous FIFO. It generalises the team's fixed 6-bit/4-entry FIFO to any data width and any power-of-two depth. It adds an occupancy output, separate almost-full and almost-empty thresholds compared with >=/<=, registered read data with a valid strobe, and an optional sticky error mode. It sits between a producer and a consumer in the transaction datapath and drives their `pause`/`can_pop` flow-control inputs directly.

## Interface
- `DATA_W`, default 6: data width in bits, >= 1.
- `DEPTH`, default 4: number of entries; power of two, >= 2.
- `AW`, localparam: $clog2(DEPTH). Pointers and counts are AW+1 bits.
- Clock and reset: clk, synchronous active-high reset.
- `clk`  in  1  clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high.
- `wr_en`  in  1  push request.
- `wr_data`  in  DATA_W  push data.
- `rd_en`  in  1  pop request.
- `af_thresh`  in  AW+1  almost-full threshold.
- `ae_thresh`  in  AW+1  almost-empty threshold.
- `err_clr`  in  1  clears sticky errors; ignored when the sticky mode is compiled out.
- `rd_data`  out  DATA_W  popped data, registered.
- `rd_valid`  out  1  rd_data is new this cycle.
- `count`  out  AW+1  occupancy, 0..DEPTH.
- `full`, `empty`  out  1 each  occupancy == DEPTH / occupancy == 0.
- `almost_full`, `almost_empty`  out  1 each  threshold flags.
- `pause`  out  1  producer must stop; equals almost_full | full.
- `can_pop`  out  1  consumer may pop; equals !empty & !almost_empty.
- `wr_error`, `rd_error`  out  1 each  rejected push / rejected pop.
- `error`  out  1  combinational wr_error | rd_error.

## Operation
- Push accepted iff `wr_en & !full`. Pop accepted iff `rd_en & !empty`. Acceptance uses the registered flags from the current cycle.
- Pointers are AW+1 bits and wrap naturally. The low AW bits address the storage.
- The next count is `count + push_acc - pop_acc`. `count`, `full`, `empty`, `almost_full` and `almost_empty` are all registered from the next count.
- `almost_full` = next_count >= af_thresh. `almost_empty` = next_count <= ae_thresh. A threshold above DEPTH means `almost_full` never asserts.
- Simultaneous push and pop when neither full nor empty: both are accepted and count is unchanged.
- Push and pop while full: the pop is accepted, the push is rejected and `wr_error` fires.
- Push and pop while empty: the push is accepted, the pop is rejected and `rd_error` fires.
- A rejected operation changes no pointer and no storage.
- An accepted pop loads `rd_data` from storage at rd_ptr. `rd_data` holds its value otherwise.
- A write to the location being read cannot occur, because the empty case rejects the pop.
- Reset values: pointers 0, count 0, full 0, empty 1, almost_full 0, almost_empty 1, pause 0, can_pop 0, rd_data 0, rd_valid 0, wr_error 0, rd_error 0.
- Storage contents are not reset.
- Reset mid-operation discards all entries on that edge. Requests presented in the reset cycle are ignored.

## Timing
- Push accepted at edge N: count and flags reflect it after edge N. The entry is poppable from cycle N+1.
- Pop accepted at edge N: rd_data and rd_valid=1 are visible after edge N, for one cycle. Latency is 1 clock from request to data.
- Back-to-back pops on consecutive cycles give consecutive rd_valid pulses.
- Error flags are registered. They are asserted for one cycle following the rejected request, and clear the next cycle unless the bad request repeats.
- The `error` output adds no extra latency.

## Configuration
- Macro: `FIFO_STICKY_ERR_EN`.
- Defined: `wr_error`/`rd_error` set on a rejected request and hold until `err_clr=1` or reset. A set and a clear on the same edge resolve to set.
- Undefined: errors are one-cycle pulses and `err_clr` is unused.

## Structure
- Package `fifo_pkg` holds the pointer-width helper (clog2 wrapper) and the flag-encoding constants shared with flow-control blocks.
- One sub-module, `fifo_ram`: a simple dual-port array (DATA_W x DEPTH) with a synchronous write port and a registered read port with read enable.
- Pointer, count, flag and error logic live in the top level.

## Test plan
All scenarios use DATA_W=6, DEPTH=4 unless stated.
- Fill and drain: after reset, push 0x01..0x04. Required: count=4, full=1, pause=1. Then pop 4 times. Required: rd_data 0x01..0x04, each with rd_valid one cycle after its pop, and empty=1 at the end.
- Overflow and underflow: push while full, then pop while empty. Required: a one-cycle wr_error pulse, then a one-cycle rd_error pulse. Pointers, count and error all behave as specified.
- Simultaneous operations: with count=2, push+pop together leaves count=2 and data order is preserved. When full, push+pop together leaves count=3 and sets wr_error. When empty, push+pop together leaves count=1 and sets rd_error.
- Thresholds: with af_thresh=3 and ae_thresh=1, count 1 gives almost_empty=1 and can_pop=0. Count 2 gives can_pop=1. Count 3 gives almost_full=1 and pause=1.
- Wrap and reset: run 10 random push/pop cycles to cross the pointer wrap and check against a scoreboard. Then assert reset with count=3. Required: count=0 and empty=1 next cycle. Repeat the run with DEPTH=16, DATA_W=8.
- Sticky mode with `FIFO_STICKY_ERR_EN` defined: a single overflow keeps wr_error=1 for 5 idle cycles. Pulsing err_clr clears it.

Source files
------------

// File: rtl/fifo_pkg.sv
// fifo_pkg
// Shared definitions for the parametrised synchronous FIFO and the
// flow-control blocks that consume its status flags.
//   fifo_ptr_w()      : address width for a given depth (clog2 wrapper)
//   FLAG_* constants  : bit positions of the packed status-flag vector
//   FLAGS_RESET       : value of that vector straight out of reset
package fifo_pkg;

  // Address width needed to index DEPTH storage entries. Pointers and
  // counts carry one extra bit on top of this.
  function automatic int fifo_ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  localparam int FLAG_FULL         = 0;
  localparam int FLAG_EMPTY        = 1;
  localparam int FLAG_ALMOST_FULL  = 2;
  localparam int FLAG_ALMOST_EMPTY = 3;
  localparam int FLAG_W            = 4;

  // An empty FIFO is both empty and almost empty, and nothing else.
  localparam logic [FLAG_W-1:0] FLAGS_RESET = 4'b1010;

endpackage

// File: rtl/fifo_ram.sv
// fifo_ram
// Simple dual-port storage array, DATA_W x DEPTH, for the FIFO.
//   clk      in   clock, rising edge
//   reset    in   synchronous active-high, clears only the read register
//   wr_en    in   write strobe
//   wr_addr  in   AW   write address
//   wr_data  in   DATA_W write data
//   rd_en    in   read enable, loads the read register
//   rd_addr  in   AW   read address
//   rd_data  out  DATA_W registered read data, holds when rd_en is low
// The array itself is never reset.
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int DATA_W = 6,
  parameter int DEPTH  = 4,
  parameter int AW     = fifo_ptr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write port: plain synchronous write, no reset so it can map onto
  // block or distributed RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read port: registered output that only updates on an enabled read,
  // so the last popped word stays visible until the next pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/fifo_sync_param.sv
// fifo_sync_param
// Parametrised synchronous FIFO (any DATA_W, power-of-two DEPTH >= 2)
// sitting between a producer and a consumer. Drives their pause/can_pop
// flow-control inputs directly.
//   clk, reset            clock and synchronous active-high reset
//   wr_en, wr_data        push request and data
//   rd_en                 pop request
//   af_thresh, ae_thresh  almost-full (>=) and almost-empty (<=) thresholds
//   err_clr               clears sticky error flags
//   rd_data, rd_valid     registered pop data and its one-cycle strobe
//   count                 occupancy 0..DEPTH
//   full, empty, almost_full, almost_empty   registered occupancy flags
//   pause, can_pop        producer stop / consumer go
//   wr_error, rd_error    rejected push / rejected pop
//   error                 wr_error | rd_error
// Build option: define FIFO_STICKY_ERR_EN to make wr_error/rd_error hold
// until err_clr or reset; otherwise they are one-cycle pulses.
module fifo_sync_param
  import fifo_pkg::*;
#(
  parameter int DATA_W = 6,
  parameter int DEPTH  = 4,
  localparam int AW    = fifo_ptr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [AW:0]       af_thresh,
  input  logic [AW:0]       ae_thresh,
  input  logic              err_clr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [AW:0]       count,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              pause,
  output logic              can_pop,
  output logic              wr_error,
  output logic              rd_error,
  output logic              error
);

  localparam logic [AW:0] CNT_ONE   = (AW+1)'(1);
  localparam logic [AW:0] CNT_DEPTH = (AW+1)'(DEPTH);

  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic [AW:0]       next_count;
  logic [FLAG_W-1:0] flags_q;
  logic [FLAG_W-1:0] next_flags;
  logic              push_acc;
  logic              pop_acc;
  logic              ram_wr_en;

  assign full         = flags_q[FLAG_FULL];
  assign empty        = flags_q[FLAG_EMPTY];
  assign almost_full  = flags_q[FLAG_ALMOST_FULL];
  assign almost_empty = flags_q[FLAG_ALMOST_EMPTY];
  assign pause        = almost_full | full;
  assign can_pop      = ~empty & ~almost_empty;
  assign error        = wr_error | rd_error;

  // Acceptance looks only at this cycle's registered flags, so a push
  // into a full FIFO is refused even if a pop frees a slot on the same
  // edge, and a pop from an empty FIFO is refused even alongside a push.
  assign push_acc  = wr_en & ~full;
  assign pop_acc   = rd_en & ~empty;
  assign ram_wr_en = push_acc & ~reset;

  // Occupancy after this edge: one up for a lone push, one down for a
  // lone pop, unchanged for both or neither.
  always_comb begin
    next_count = count;
    if (push_acc && !pop_acc) begin
      next_count = count + CNT_ONE;
    end else if (!push_acc && pop_acc) begin
      next_count = count - CNT_ONE;
    end
  end

  // All status flags are derived from the next occupancy so they line up
  // with count on the same edge. A threshold above DEPTH can never be
  // reached, which disables almost_full.
  always_comb begin
    next_flags                    = '0;
    next_flags[FLAG_FULL]         = (next_count == CNT_DEPTH);
    next_flags[FLAG_EMPTY]        = (next_count == '0);
    next_flags[FLAG_ALMOST_FULL]  = (next_count >= af_thresh);
    next_flags[FLAG_ALMOST_EMPTY] = (next_count <= ae_thresh);
  end

  // Pointer, occupancy and pop-strobe registers. Pointers are one bit
  // wider than the storage address and simply wrap; only the low AW bits
  // go to the RAM.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      flags_q  <= FLAGS_RESET;
      rd_valid <= 1'b0;
    end else begin
      if (push_acc) begin
        wr_ptr <= wr_ptr + CNT_ONE;
      end
      if (pop_acc) begin
        rd_ptr <= rd_ptr + CNT_ONE;
      end
      count    <= next_count;
      flags_q  <= next_flags;
      rd_valid <= pop_acc;
    end
  end

  // Error flags record a refused request. In sticky mode a fresh error on
  // the same edge as err_clr wins, so no event is ever lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_error <= 1'b0;
      rd_error <= 1'b0;
    end else begin
`ifdef FIFO_STICKY_ERR_EN
      wr_error <= (wr_en & full) | (wr_error & ~err_clr);
      rd_error <= (rd_en & empty) | (rd_error & ~err_clr);
`else
      wr_error <= wr_en & full;
      rd_error <= rd_en & empty;
`endif
    end
  end

`ifndef FIFO_STICKY_ERR_EN
  logic err_clr_unused;
  assign err_clr_unused = err_clr;
`endif

  fifo_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (ram_wr_en),
    .wr_addr (wr_ptr[AW-1:0]),
    .wr_data (wr_data),
    .rd_en   (pop_acc),
    .rd_addr (rd_ptr[AW-1:0]),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_fifo_sync_param.sv
// tb_fifo_sync_param
// Self-checking bench for fifo_sync_param. Two instances run side by side:
// instance 0 is DATA_W=6/DEPTH=4, instance 1 is DATA_W=8/DEPTH=16. A queue
// per instance models the FIFO contents; expected flags are recomputed
// from queue size and thresholds. Define FIFO_STICKY_ERR_EN for both RTL
// and bench to exercise sticky errors.
module tb_fifo_sync_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       a_reset = 1'b1, a_wr_en = 1'b0, a_rd_en = 1'b0, a_err_clr = 1'b0;
  logic [5:0] a_wr_data = '0;
  logic [2:0] a_af = 3'd4, a_ae = 3'd0;
  logic [5:0] a_rd_data;
  logic [2:0] a_count;
  logic       a_rd_valid, a_full, a_empty, a_almost_full, a_almost_empty;
  logic       a_pause, a_can_pop, a_wr_error, a_rd_error, a_error;

  logic       b_reset = 1'b1, b_wr_en = 1'b0, b_rd_en = 1'b0, b_err_clr = 1'b0;
  logic [7:0] b_wr_data = '0;
  logic [4:0] b_af = 5'd16, b_ae = 5'd0;
  logic [7:0] b_rd_data;
  logic [4:0] b_count;
  logic       b_rd_valid, b_full, b_empty, b_almost_full, b_almost_empty;
  logic       b_pause, b_can_pop, b_wr_error, b_rd_error, b_error;

  int checks = 0;
  int failures = 0;

  logic [7:0] qa[$];
  logic [7:0] qb[$];
  logic [7:0] m_rd_data [2];
  bit         m_rd_valid [2];
  bit         m_wr_err [2];
  bit         m_rd_err [2];
  bit         m_af [2];
  bit         m_ae [2];

  fifo_sync_param #(.DATA_W(6), .DEPTH(4)) dut_a (
    .clk(clk), .reset(a_reset), .wr_en(a_wr_en), .wr_data(a_wr_data),
    .rd_en(a_rd_en), .af_thresh(a_af), .ae_thresh(a_ae), .err_clr(a_err_clr),
    .rd_data(a_rd_data), .rd_valid(a_rd_valid), .count(a_count),
    .full(a_full), .empty(a_empty), .almost_full(a_almost_full),
    .almost_empty(a_almost_empty), .pause(a_pause), .can_pop(a_can_pop),
    .wr_error(a_wr_error), .rd_error(a_rd_error), .error(a_error)
  );

  fifo_sync_param #(.DATA_W(8), .DEPTH(16)) dut_b (
    .clk(clk), .reset(b_reset), .wr_en(b_wr_en), .wr_data(b_wr_data),
    .rd_en(b_rd_en), .af_thresh(b_af), .ae_thresh(b_ae), .err_clr(b_err_clr),
    .rd_data(b_rd_data), .rd_valid(b_rd_valid), .count(b_count),
    .full(b_full), .empty(b_empty), .almost_full(b_almost_full),
    .almost_empty(b_almost_empty), .pause(b_pause), .can_pop(b_can_pop),
    .wr_error(b_wr_error), .rd_error(b_rd_error), .error(b_error)
  );

  // Packed snapshot of everything an instance shows the outside world:
  // {count[4:0], full, empty, af, ae, pause, can_pop, rd_valid, wr_err,
  //  rd_err, error, rd_data[7:0]}
  function automatic logic [22:0] observed(input int sel);
    if (sel == 0)
      return {2'b00, a_count, a_full, a_empty, a_almost_full, a_almost_empty,
              a_pause, a_can_pop, a_rd_valid, a_wr_error, a_rd_error, a_error,
              2'b00, a_rd_data};
    return {b_count, b_full, b_empty, b_almost_full, b_almost_empty,
            b_pause, b_can_pop, b_rd_valid, b_wr_error, b_rd_error, b_error,
            b_rd_data};
  endfunction

  // Same snapshot as the model believes it should be.
  function automatic logic [22:0] exp_vec(input int sel);
    int cnt;
    bit f, e;
    cnt = (sel == 0) ? qa.size() : qb.size();
    f = (cnt == ((sel == 0) ? 4 : 16));
    e = (cnt == 0);
    return {5'(cnt), f, e, m_af[sel], m_ae[sel], m_af[sel] | f,
            !e && !m_ae[sel], m_rd_valid[sel], m_wr_err[sel], m_rd_err[sel],
            m_wr_err[sel] | m_rd_err[sel], m_rd_data[sel]};
  endfunction

  // Drives one clock of requests into instance sel and advances the model
  // through that edge. Outputs are settled when it returns (#1 after edge).
  task automatic applyStimulus(input int sel, input bit wr, input logic [7:0] d,
                               input bit rd, input bit clr, input bit rst);
    int depth, sz, thr_af, thr_ae;
    bit push_ok, pop_ok, wr_rej, rd_rej;
    depth = (sel == 0) ? 4 : 16;
    sz    = (sel == 0) ? qa.size() : qb.size();
    if (sel == 0) begin
      a_wr_en = wr; a_wr_data = d[5:0]; a_rd_en = rd; a_err_clr = clr; a_reset = rst;
      thr_af = int'(a_af); thr_ae = int'(a_ae);
    end else begin
      b_wr_en = wr; b_wr_data = d; b_rd_en = rd; b_err_clr = clr; b_reset = rst;
      thr_af = int'(b_af); thr_ae = int'(b_ae);
    end
    @(posedge clk);
    if (rst) begin
      if (sel == 0) qa.delete(); else qb.delete();
      m_rd_data[sel] = '0; m_rd_valid[sel] = 1'b0;
      m_wr_err[sel] = 1'b0; m_rd_err[sel] = 1'b0;
      m_af[sel] = 1'b0; m_ae[sel] = 1'b1;
    end else begin
      push_ok = wr && (sz < depth);
      pop_ok  = rd && (sz > 0);
      if (pop_ok) m_rd_data[sel] = (sel == 0) ? qa.pop_front() : qb.pop_front();
      m_rd_valid[sel] = pop_ok;
      if (push_ok) begin
        if (sel == 0) qa.push_back(d & 8'h3f); else qb.push_back(d);
      end
      wr_rej = wr && !push_ok;
      rd_rej = rd && !pop_ok;
`ifdef FIFO_STICKY_ERR_EN
      m_wr_err[sel] = wr_rej || (m_wr_err[sel] && !clr);
      m_rd_err[sel] = rd_rej || (m_rd_err[sel] && !clr);
`else
      m_wr_err[sel] = wr_rej;
      m_rd_err[sel] = rd_rej;
`endif
      sz = (sel == 0) ? qa.size() : qb.size();
      m_af[sel] = (sz >= thr_af);
      m_ae[sel] = (sz <= thr_ae);
    end
    #1;
    if (sel == 0) begin
      a_wr_en = 1'b0; a_rd_en = 1'b0; a_err_clr = 1'b0; a_reset = 1'b0;
    end else begin
      b_wr_en = 1'b0; b_rd_en = 1'b0; b_err_clr = 1'b0; b_reset = 1'b0;
    end
  endtask

  // Reset state of both instances.
  task automatic test_reset();
    applyStimulus(0, 0, 8'h00, 0, 0, 1);
    applyStimulus(1, 0, 8'h00, 0, 0, 1);
    checks++;
    if (observed(0) !== exp_vec(0)) begin
      failures++;
      $display("[TB] FAIL reset_a: got %h expected %h", observed(0), exp_vec(0));
    end
    checks++;
    if (observed(1) !== exp_vec(1)) begin
      failures++;
      $display("[TB] FAIL reset_b: got %h expected %h", observed(1), exp_vec(1));
    end
    checks++;
    if ({a_count, a_empty, a_almost_empty, a_pause, a_can_pop, a_rd_valid} !== 8'b000_11000) begin
      failures++;
      $display("[TB] FAIL reset_a_literal: got %b expected 00011000",
               {a_count, a_empty, a_almost_empty, a_pause, a_can_pop, a_rd_valid});
    end
  endtask

  // Push 1..4 then pop four times; data returns in order one clock later.
  task automatic test_fill_drain();
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(0, 1, 8'(i), 0, 0, 0);
      checks++;
      if (observed(0) !== exp_vec(0)) begin
        failures++;
        $display("[TB] FAIL fill_push%0d: got %h expected %h", i, observed(0), exp_vec(0));
      end
    end
    checks++;
    if ({a_count, a_full, a_pause} !== {3'd4, 1'b1, 1'b1}) begin
      failures++;
      $display("[TB] FAIL fill_full: got count=%0d full=%b pause=%b expected 4 1 1",
               a_count, a_full, a_pause);
    end
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(0, 0, 8'h00, 1, 0, 0);
      checks++;
      if (observed(0) !== exp_vec(0)) begin
        failures++;
        $display("[TB] FAIL drain_pop%0d: got %h expected %h", i, observed(0), exp_vec(0));
      end
      checks++;
      if ({a_rd_valid, a_rd_data} !== {1'b1, 6'(i)}) begin
        failures++;
        $display("[TB] FAIL drain_data%0d: got valid=%b data=%h expected 1 %h",
                 i, a_rd_valid, a_rd_data, 6'(i));
      end
    end
    applyStimulus(0, 0, 8'h00, 0, 0, 0);
    checks++;
    if ({a_empty, a_rd_valid} !== 2'b10) begin
      failures++;
      $display("[TB] FAIL drain_end: got empty=%b valid=%b expected 1 0", a_empty, a_rd_valid);
    end
  endtask

  // Push while full, then pop while empty; errors follow the model.
  task automatic test_overflow_underflow();
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, 8'(8'h20 + i), 0, 0, 0);
    applyStimulus(0, 1, 8'h3f, 0, 0, 0);
    checks++;
    if (observed(0) !== exp_vec(0) || a_wr_error !== 1'b1) begin
      failures++;
      $display("[TB] FAIL overflow: got %h expected %h", observed(0), exp_vec(0));
    end
    applyStimulus(0, 0, 8'h00, 0, 0, 0);
    checks++;
    if (observed(0) !== exp_vec(0)) begin
      failures++;
      $display("[TB] FAIL overflow_after: got %h expected %h", observed(0), exp_vec(0));
    end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 8'h00, 1, 0, 0);
      checks++;
      if (observed(0) !== exp_vec(0)) begin
        failures++;
        $display("[TB] FAIL ovf_drain%0d: got %h expected %h", i, observed(0), exp_vec(0));
      end
    end
    applyStimulus(0, 0, 8'h00, 1, 0, 0);
    checks++;
    if (observed(0) !== exp_vec(0) || a_rd_error !== 1'b1 || a_count !== 3'd0) begin
      failures++;
      $display("[TB] FAIL underflow: got %h expected %h", observed(0), exp_vec(0));
    end
    applyStimulus(0, 0, 8'h00, 0, 1, 0);
    checks++;
    if (observed(0) !== exp_vec(0)) begin
      failures++;
      $display("[TB] FAIL underflow_after: got %h expected %h", observed(0), exp_vec(0));
    end
  endtask

  // Push+pop together in the middle, when full and when empty.
  task automatic test_simultaneous();
    applyStimulus(0, 0, 8'h00, 0, 0, 1);
    applyStimulus(0, 1, 8'h11, 0, 0, 0);
    applyStimulus(0, 1, 8'h22, 0, 0, 0);
    applyStimulus(0, 1, 8'h33, 1, 0, 0);
    checks++;
    if (observed(0) !== exp_vec(0) || a_count !== 3'd2 || a_rd_data !== 6'h11) begin
      failures++;
      $display("[TB] FAIL simul_mid: got %h expected %h", observed(0), exp_vec(0));
    end
    for (int i = 0; i < 2; i++) begin
      applyStimulus(0, 0, 8'h00, 1, 0, 0);
      checks++;
      if (observed(0) !== exp_vec(0)) begin
        failures++;
        $display("[TB] FAIL simul_order%0d: got %h expected %h", i, observed(0), exp_vec(0));
      end
    end
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, 8'(8'h05 + i), 0, 0, 0);
    applyStimulus(0, 1, 8'h2a, 1, 0, 0);
    checks++;
    if (observed(0) !== exp_vec(0) || a_count !== 3'd3 || a_wr_error !== 1'b1) begin
      failures++;
      $display("[TB] FAIL simul_full: got %h expected %h", observed(0), exp_vec(0));
    end
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 8'h00, 1, 1, 0);
    applyStimulus(0, 1, 8'h15, 1, 0, 0);
    checks++;
    if (observed(0) !== exp_vec(0) || a_count !== 3'd1 || a_rd_error !== 1'b1) begin
      failures++;
      $display("[TB] FAIL simul_empty: got %h expected %h", observed(0), exp_vec(0));
    end
    applyStimulus(0, 0, 8'h00, 0, 0, 1);
  endtask

  // af_thresh=3, ae_thresh=1 walked through occupancies 1..3.
  task automatic test_thresholds();
    a_af = 3'd3;
    a_ae = 3'd1;
    applyStimulus(0, 0, 8'h00, 0, 0, 1);
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(0, 1, 8'(i), 0, 0, 0);
      checks++;
      if (observed(0) !== exp_vec(0)) begin
        failures++;
        $display("[TB] FAIL thresh_cnt%0d: got %h expected %h", i, observed(0), exp_vec(0));
      end
      checks++;
      if ({a_almost_empty, a_can_pop, a_almost_full, a_pause} !==
          {i == 1, i >= 2, i == 3, i == 3}) begin
        failures++;
        $display("[TB] FAIL thresh_flags%0d: got ae=%b cp=%b af=%b pause=%b",
                 i, a_almost_empty, a_can_pop, a_almost_full, a_pause);
      end
    end
    a_af = 3'd4;
    a_ae = 3'd0;
    applyStimulus(0, 0, 8'h00, 0, 0, 1);
  endtask

  // Random push/pop across the pointer wrap, then reset with three entries.
  task automatic test_wrap_reset(input int sel);
    int n, pre, depth;
    logic [22:0] cur;
    depth = (sel == 0) ? 4 : 16;
    n     = (sel == 0) ? 10 : 40;
    pre   = depth / 2;
    for (int i = 0; i < pre; i++) applyStimulus(sel, 1, 8'($urandom), 0, 0, 0);
    for (int i = 0; i < n; i++) begin
      applyStimulus(sel, 1'($urandom_range(0, 1)), 8'($urandom),
                    1'($urandom_range(0, 1)), 1, 0);
      checks++;
      if (observed(sel) !== exp_vec(sel)) begin
        failures++;
        $display("[TB] FAIL wrap%0d_cycle%0d: got %h expected %h",
                 sel, i, observed(sel), exp_vec(sel));
      end
    end
    for (int i = 0; i < depth; i++) applyStimulus(sel, 0, 8'h00, 1, 1, 0);
    for (int i = 0; i < 3; i++) applyStimulus(sel, 1, 8'($urandom), 0, 0, 0);
    cur = observed(sel);
    checks++;
    if (cur[22:18] !== 5'd3) begin
      failures++;
      $display("[TB] FAIL wrap%0d_count3: got %0d expected 3", sel, cur[22:18]);
    end
    applyStimulus(sel, 1, 8'h55, 1, 0, 1);
    cur = observed(sel);
    checks++;
    if (cur !== exp_vec(sel) || cur[22:18] !== 5'd0 || cur[16] !== 1'b1) begin
      failures++;
      $display("[TB] FAIL wrap%0d_reset: got %h expected %h", sel, cur, exp_vec(sel));
    end
  endtask

  // Single overflow then idle; sticky builds hold wr_error until err_clr.
  task automatic test_sticky();
    applyStimulus(0, 0, 8'h00, 0, 0, 1);
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, 8'(i), 0, 0, 0);
    applyStimulus(0, 1, 8'h3c, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 0, 8'h00, 0, 0, 0);
      checks++;
      if (observed(0) !== exp_vec(0)) begin
        failures++;
        $display("[TB] FAIL sticky_idle%0d: got %h expected %h", i, observed(0), exp_vec(0));
      end
`ifdef FIFO_STICKY_ERR_EN
      checks++;
      if (a_wr_error !== 1'b1) begin
        failures++;
        $display("[TB] FAIL sticky_hold%0d: got %b expected 1", i, a_wr_error);
      end
`endif
    end
    applyStimulus(0, 1, 8'h3d, 0, 1, 0);
    checks++;
    if (observed(0) !== exp_vec(0) || a_wr_error !== 1'b1) begin
      failures++;
      $display("[TB] FAIL sticky_set_wins: got %h expected %h", observed(0), exp_vec(0));
    end
    applyStimulus(0, 0, 8'h00, 0, 1, 0);
    checks++;
    if (observed(0) !== exp_vec(0) || a_wr_error !== 1'b0) begin
      failures++;
      $display("[TB] FAIL sticky_clear: got %h expected %h", observed(0), exp_vec(0));
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_fill_drain();
    test_overflow_underflow();
    test_simultaneous();
    test_thresholds();
    test_wrap_reset(0);
    test_wrap_reset(1);
    test_sticky();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
